// File: rtl/alu_hazard_ctrl.sv
// Issue and hazard controller for the 16-bit ALU execute stage.
// Tracks EX/MEM destinations, produces forwarding selects, inserts load-use bubbles, counts stalls.
module alu_hazard_ctrl #(
  parameter logic [3:0] NONE_IDX = 4'hF,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_we,
  input  logic             id_load,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rm,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0] ex_rd;
  logic       ex_we;
  logic       ex_load;
  logic       ex_v;
  logic [3:0] mem_rd;
  logic       mem_we;
  logic       mem_v;

  logic rs_hit_ex, rm_hit_ex, rs_hit_mem, rm_hit_mem;
  logic lu;

  function automatic logic slot_hit(input logic v, input logic we,
                                    input logic [3:0] rd, input logic [3:0] src);
    return v && we && (rd == src) && (src != NONE_IDX);
  endfunction

  assign rs_hit_ex  = slot_hit(ex_v,  ex_we,  ex_rd,  id_rs);
  assign rm_hit_ex  = slot_hit(ex_v,  ex_we,  ex_rd,  id_rm);
  assign rs_hit_mem = slot_hit(mem_v, mem_we, mem_rd, id_rs);
  assign rm_hit_mem = slot_hit(mem_v, mem_we, mem_rd, id_rm);

  assign lu     = id_valid && ex_load && (rs_hit_ex || rm_hit_ex);
  assign stall  = mem_busy || (lu && !flush);
  assign bubble = !mem_busy && (flush || lu || !id_valid);

  // A loaded value is not available in EX, so only non-load EX results forward.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    fwd_rs = FWD_RF;
    fwd_rm = FWD_RF;
    if (!lu) begin
      if (rs_hit_ex && !ex_load) fwd_rs = FWD_EX;
      else if (rs_hit_mem)       fwd_rs = FWD_MEM;
      if (rm_hit_ex && !ex_load) fwd_rm = FWD_EX;
      else if (rm_hit_mem)       fwd_rm = FWD_MEM;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so the MEM slot sees the old EX slot.
    if (rst) begin
      // NOTE: the rd/we fields are reset too so no X can reach the match comparators.
      ex_v    <= 1'b0;
      ex_we   <= 1'b0;
      ex_load <= 1'b0;
      ex_rd   <= NONE_IDX;
      mem_v   <= 1'b0;
      mem_we  <= 1'b0;
      mem_rd  <= NONE_IDX;
    end else if (!mem_busy) begin
      mem_v  <= ex_v;
      mem_we <= ex_we;
      mem_rd <= ex_rd;
      if (bubble) begin
        ex_v    <= 1'b0;
        ex_we   <= 1'b0;
        ex_load <= 1'b0;
        ex_rd   <= NONE_IDX;
      end else begin
        ex_v    <= 1'b1;
        ex_we   <= id_we;
        ex_load <= id_load;
        ex_rd   <= id_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                stall_cnt <= '0;
    else if (stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: doc/alu_hazard_ctrl.md
# alu_hazard_ctrl

Issue and hazard controller for the 16-bit ALU execute stage of the five-stage pipeline. It tracks the destinations of the instructions in EX and MEM and produces operand-forwarding selects for the ALU `rs`/`rm` inputs. It detects load-use hazards and inserts NOP bubbles into EX. It also honours branch flushes and data-memory freezes, and keeps a saturating stall-cycle counter for debug.

## Interface
Parameters:
- `NONE_IDX`, default 4'hF, register index meaning "no register"; it never matches anything.
- `CNT_W`, default 16, width of the stall counter.

Ports:
- `clk`, input, 1 bit: single system clock. All state updates on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `id_valid`, input, 1 bit: the ID stage holds a real instruction.
- `id_rs`, input, 4 bits: source index 1. Values 0–7 are R0–R7, 8 is SP, 9 is IH, 10 is RA, 11 is T, and 15 is none.
- `id_rm`, input, 4 bits: source index 2, same encoding as `id_rs`.
- `id_rd`, input, 4 bits: destination index. It includes 11 for T, which is written by slt/sltu/slti/sltui/cmp/cmpi.
- `id_we`, input, 1 bit: the ID instruction writes `id_rd`.
- `id_load`, input, 1 bit: the ID instruction is lw or lw_sp.
- `flush`, input, 1 bit: a taken branch or jump; kill the ID instruction.
- `mem_busy`, input, 1 bit: the data memory is multi-cycle busy; freeze the whole pipeline.
- `stall`, output, 1 bit: hold PC, IF/ID and ID.
- `bubble`, output, 1 bit: EX receives a NOP (16'b0000100000000000) this edge.
- `fwd_rs`, output, 2 bits: ALU `rs` source. 00 selects the register file, 01 the EX result, 10 the MEM result.
- `fwd_rm`, output, 2 bits: same encoding for ALU `rm`.
- `stall_cnt`, output, `CNT_W` bits: count of cycles with `stall`=1, saturating.

## Operation
- Internal slots:
  - EX slot: `ex_rd`, `ex_we`, `ex_load`, `ex_v`.
  - MEM slot: `mem_rd`, `mem_we`, `mem_v`.
- Match rule: a source matches a slot iff all of the following hold:
  - the slot's valid bit is 1;
  - the slot's write enable is 1;
  - the slot's rd equals the source index;
  - the source index is not `NONE_IDX`.
- Load-use: `lu` = `id_valid` and EX slot has `ex_load`=1 and (`id_rs` matches EX or `id_rm` matches EX).
- Combinational outputs:
  - `stall` = `mem_busy` or (`lu` and not `flush`).
  - `bubble` = not `mem_busy` and (`flush` or `lu` or not `id_valid`).
  - `fwd_x` = 01 if x matches EX and `ex_load`=0; otherwise 10 if x matches MEM; otherwise 00. EX has priority over MEM.
  - `fwd_x` is forced to 00 while `lu` is active, since the bubble makes the value irrelevant.
- Priority: `rst` > `mem_busy` > `flush` > load-use.
- Slot update on each rising edge, unless `rst` or `mem_busy`:
  - MEM slot takes the EX slot.
  - EX slot takes the ID fields if `bubble`=0; otherwise it is cleared (`ex_v`=0).
- During `mem_busy`: both slots hold, and the outputs are recomputed from the held slots.
- `stall_cnt` increments by 1 on every edge where `stall`=1 and `rst`=0. It holds at all-ones.

## Timing
- Reset, synchronous to `clk`:
  - `ex_v`=`mem_v`=0 and `stall_cnt`=0 after the edge.
  - With the slots invalid, the outputs settle to `stall`=0 and `fwd_rs`=`fwd_rm`=00 in the following cycle, given `mem_busy`=0 and `flush`=0.
  - `bubble` follows its combinational equation; for example, `bubble`=1 when `id_valid`=0.
- Latency: the forwarding selects and `stall` are combinational in the same cycle as the ID inputs. Slot state lags the ID stage by exactly one edge.
- A load-use stall lasts exactly 1 cycle. After the bubble edge the load sits in MEM, so the dependent instruction gets `fwd`=10 and `stall`=0.
- `flush` and `lu` in the same cycle: `stall`=0 and `bubble`=1. The dependent instruction is discarded.
- `mem_busy` and `flush` in the same cycle: freeze wins. `flush` must be held by its source until `mem_busy` drops.
- Reset asserted mid-stall or mid-freeze: the next edge clears the slots and the counter. No pending bubble survives the reset.
- Index 15 never forwards or stalls, even if a slot holds rd=15 with we=1.

## Test plan
1. Reset: hold `rst`=1 for 2 cycles with random inputs. Release with `id_valid`=0, `mem_busy`=0, `flush`=0. Required: `stall`=0, `bubble`=1, `fwd_rs`=`fwd_rm`=00 and `stall_cnt`=0 after the first edge.
2. Forwarding: issue `addu` with rd=3, then `subu` with rs=3 and rm=3. Required: `fwd_rs`=`fwd_rm`=01 in the second instruction's ID cycle. An instruction with rs=3 one cycle later gets 10.
3. Load-use: issue `lw` with rd=2, then `and` with rs=2. Required: `stall`=1 and `bubble`=1 for one cycle, then `fwd_rs`=10 and `stall`=0. `stall_cnt` becomes 1.
4. T hazard: issue `cmp` writing rd=11, then `bteqz` reading rs=11. Required: `fwd_rs`=01. With a lw to r5 in MEM and `cmp` in EX, the selects for rs=11 and rm=5 are 01 and 10.
5. Flush during load-use: assert `flush`=1 in the same cycle as the load-use condition. Required: `stall`=0 and `bubble`=1, and the EX slot is invalid on the next edge.
6. Freeze and saturation: hold `mem_busy`=1 for 3 cycles. Required: the slots are unchanged, `stall`=1 and `bubble`=0, and `stall_cnt` rises by 3. Preload to 16'hFFFE and hold `mem_busy`; required: the counter stays at 16'hFFFF.
